// File: rtl/ram_2_port.sv
// Single-clock command-driven RAM: a 10-bit command/data stream sets the write
// and read addresses, writes words and issues registered reads.
module ram_2_port #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [1:0]           cmd;

    assign cmd = din[9:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the whole array is cleared on reset, so it maps to flops
            // rather than a RAM macro; this is intentional for this block.
            mem      <= '{default: 8'h00};
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            // tx_valid is a one-cycle strobe; only a read command re-asserts it.
            tx_valid <= 1'b0;
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr       <= din[ADDR_SIZE-1:0];
                    CMD_WR_DATA: mem[wr_addr]  <= din[7:0];
                    CMD_RD_ADDR: rd_addr       <= din[ADDR_SIZE-1:0];
                    CMD_RD_DATA: begin
                        dout     <= mem[rd_addr];
                        tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_2_port.sv
// Directed self-checking bench for ram_2_port: reset, write/read, gating,
// independent addresses, overwrite, read-after-write and reset mid-sequence.
module tb_ram_2_port;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ram_2_port #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word for one edge, then sample #1 after that edge.
    task automatic send(input logic [1:0] cmd, input logic [7:0] data, input logic valid);
        din      = {cmd, data};
        rx_valid = valid;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        din      = '0;
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 00", dout);
        end
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
        end
        rst_n = 1'b1;
        send(2'b10, 8'h0A, 1'b1);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_addr_no_tx: got %b expected 0", tx_valid);
        end
        send(2'b11, 8'h5C, 1'b1);
        n_checks++;
        if (dout !== 8'h00 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read: got dout=%h tx=%b expected dout=00 tx=1", dout, tx_valid);
        end
        idle();
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read_strobe: got tx=%b expected 0", tx_valid);
        end
    endtask

    task automatic test_write_read();
        send(2'b00, 8'h0A, 1'b1);
        send(2'b01, 8'h0B, 1'b1);
        send(2'b10, 8'h0A, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h0B || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read: got dout=%h tx=%b expected dout=0b tx=1", dout, tx_valid);
        end
        idle();
        n_checks++;
        if (dout !== 8'h0B || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_read_hold: got dout=%h tx=%b expected dout=0b tx=0", dout, tx_valid);
        end
    endtask

    task automatic test_gating();
        // A gated write of 0xFF to the still-loaded wr_addr 0x0A must be ignored.
        send(2'b01, 8'hFF, 1'b0);
        n_checks++;
        if (dout !== 8'h0B || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gating_idle: got dout=%h tx=%b expected dout=0b tx=0", dout, tx_valid);
        end
        send(2'b11, 8'h00, 1'b0);
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gating_read: got tx=%b expected 0", tx_valid);
        end
        send(2'b10, 8'h0A, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h0B || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gating_data: got dout=%h tx=%b expected dout=0b tx=1", dout, tx_valid);
        end
    endtask

    task automatic test_back_to_back();
        send(2'b00, 8'h00, 1'b1);
        send(2'b01, 8'h55, 1'b1);
        send(2'b00, 8'hFF, 1'b1);
        send(2'b01, 8'hAA, 1'b1);
        send(2'b10, 8'hFF, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'hAA || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got dout=%h tx=%b expected dout=aa tx=1", dout, tx_valid);
        end
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'hAA || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got dout=%h tx=%b expected dout=aa tx=1", dout, tx_valid);
        end
        idle();
        n_checks++;
        if (dout !== 8'hAA || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got dout=%h tx=%b expected dout=aa tx=0", dout, tx_valid);
        end
        send(2'b10, 8'h00, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h55) begin
            n_fail++;
            $display("FAIL addr_zero: got %h expected 55", dout);
        end
    endtask

    task automatic test_overwrite_and_raw();
        send(2'b00, 8'h10, 1'b1);
        send(2'b01, 8'h11, 1'b1);
        send(2'b01, 8'h22, 1'b1);
        send(2'b10, 8'h10, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h22) begin
            n_fail++;
            $display("FAIL overwrite: got %h expected 22", dout);
        end
        // Write immediately followed by a read of the same location.
        send(2'b00, 8'h20, 1'b1);
        send(2'b10, 8'h20, 1'b1);
        send(2'b01, 8'hC3, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'hC3 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL read_after_write: got dout=%h tx=%b expected dout=c3 tx=1", dout, tx_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(2'b00, 8'h0A, 1'b1);
        // Reset and a pending write at the same edge: reset must win.
        rst_n = 1'b0;
        send(2'b01, 8'hEE, 1'b1);
        rst_n = 1'b1;
        n_checks++;
        if (dout !== 8'h00 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got dout=%h tx=%b expected dout=00 tx=0", dout, tx_valid);
        end
        send(2'b01, 8'h77, 1'b1);
        send(2'b10, 8'h00, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h77 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_addr0: got dout=%h tx=%b expected dout=77 tx=1", dout, tx_valid);
        end
        send(2'b10, 8'h0A, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_cleared: got %h expected 00", dout);
        end
        send(2'b10, 8'hFF, 1'b1);
        send(2'b11, 8'h00, 1'b1);
        n_checks++;
        if (dout !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_cleared_ff: got %h expected 00", dout);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_gating();
        test_back_to_back();
        test_overwrite_and_raw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
